// File: rtl/iob_fifo_sync_wr_arb.sv
// Round-robin write arbiter sharing one sync FIFO write port among NUM_REQ producers.
// A grant is held for a whole packet, or for MAX_BURST beats when MAX_BURST is non-zero.
module iob_fifo_sync_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 0,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fifo_w_en,
  output logic [DATA_W-1:0]           fifo_w_data,
  input  logic                        fifo_w_full,
  output logic                        grant_valid,
  output logic [ID_W-1:0]             grant_id
);

  localparam int BC_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0] BURST_LAST = (MAX_BURST == 0) ? '0 : BC_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0]             sel;
  logic [NUM_REQ-1:0][DATA_W-1:0] lane_data;
  logic [DATA_W-1:0]              mux_data;
  logic                           own_valid, own_last, xfer, release_now;
  logic                           pick_vld;
  logic [ID_W-1:0]                pick_id;
  logic [ID_W:0]                  cand;

  // One-hot owner select; all zero while idle so nothing leaks to the FIFO.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign sel[i]       = (state_q == GRANT) && (grant_id_q == ID_W'(i));
    assign lane_data[i] = sel[i] ? req_data[i*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_REQ; i++) mux_data = mux_data | lane_data[i];
  end

  assign own_valid   = |(req_valid & sel);
  assign own_last    = |(req_last & sel);
  assign xfer        = own_valid & ~fifo_w_full;
  assign release_now = xfer & (own_last | ((MAX_BURST != 0) && (beat_cnt_q == BURST_LAST)));

  assign req_ready   = sel & {NUM_REQ{xfer}};
  assign fifo_w_en   = xfer;
  assign fifo_w_data = mux_data;
  assign grant_valid = (state_q == GRANT);
  assign grant_id    = grant_id_q;

  // Walk from farthest to nearest after rr_ptr so the nearest valid requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (req_valid[cand[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = GRANT;
          grant_id_d = pick_id;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d    = IDLE;
          rr_ptr_d   = grant_id_q;
          beat_cnt_d = '0;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_iob_fifo_sync_wr_arb.sv
// Bench for iob_fifo_sync_wr_arb: a directed vector table plus hand sequences, and random
// traffic against a packet-level reference model, on an unlimited-burst and a MAX_BURST=2 instance.
module tb_iob_fifo_sync_wr_arb;
  localparam int N = 4;
  localparam int W = 32;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic [N-1:0]     req_valid, req_last;
  logic [N*W-1:0]   req_data;
  logic             fifo_w_full;

  logic [N-1:0]     rdy [2];
  logic             wen [2];
  logic [W-1:0]     wd  [2];
  logic             gv  [2];
  logic [1:0]       gid [2];

  int nvec = 0;
  int nerr = 0;

  always #5 ap_clk = ~ap_clk;

  iob_fifo_sync_wr_arb #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(0)) dut0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy[0]), .fifo_w_en(wen[0]), .fifo_w_data(wd[0]),
    .fifo_w_full(fifo_w_full), .grant_valid(gv[0]), .grant_id(gid[0]));

  iob_fifo_sync_wr_arb #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(2)) dut2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy[1]), .fifo_w_en(wen[1]), .fifo_w_data(wd[1]),
    .fifo_w_full(fifo_w_full), .grant_valid(gv[1]), .grant_id(gid[1]));

  // Reference model: who owns the port, who owned it last, beats sent in this grant.
  int own [2];
  int lown[2];
  int beats[2];
  int mb  [2] = '{0, 2};

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; lown[d] = N - 1; beats[d] = 0;
    end
  endtask

  function automatic logic m_wen(int d);
    return (own[d] >= 0) && req_valid[own[d]] && !fifo_w_full;
  endfunction

  task automatic mcheck();
    for (int d = 0; d < 2; d++) begin
      logic         e_gv, e_wen;
      logic [N-1:0] e_rdy;
      logic [W-1:0] e_wd;
      e_gv  = own[d] >= 0;
      e_wen = m_wen(d);
      e_rdy = e_wen ? N'(1 << own[d]) : '0;
      e_wd  = e_gv ? req_data[own[d]*W +: W] : '0;
      nvec++;
      if (gv[d] !== e_gv || wen[d] !== e_wen || rdy[d] !== e_rdy || wd[d] !== e_wd ||
          (e_gv && int'(gid[d]) != own[d])) begin
        nerr++;
        $display("FAIL model dut%0d t=%0t: got gv=%b id=%0d wen=%b rdy=%b data=%h, expected gv=%b id=%0d wen=%b rdy=%b data=%h",
                 d, $time, gv[d], gid[d], wen[d], rdy[d], wd[d], e_gv, own[d], e_wen, e_rdy, e_wd);
      end
    end
  endtask

  task automatic mstep();
    for (int d = 0; d < 2; d++) begin
      if (own[d] < 0) begin
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (lown[d] + k) % N;
          if (own[d] < 0 && req_valid[idx]) own[d] = idx;
        end
      end else if (m_wen(d)) begin
        beats[d]++;
        if (req_last[own[d]] || (mb[d] != 0 && beats[d] == mb[d])) begin
          lown[d] = own[d]; own[d] = -1; beats[d] = 0;
        end
      end
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
  endtask

  // Finish a cycle already sampled at the negedge: model check/step, then advance past posedge.
  task automatic tick_post();
    mcheck();
    mstep();
    @(posedge ap_clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         f;
    logic         gv;
    logic [1:0]   gid;
    logic         wen;
    logic [N-1:0] rdy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [W-1:0] e_wd;
    logic         bgv  [7] = '{0, 1, 1, 0, 1, 0, 1};
    logic [1:0]   bgid [7] = '{0, 1, 1, 0, 3, 0, 1};

    // single requester, 3-beat packet
    tbl.push_back('{4'b0001, 4'b0000, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{4'b0001, 4'b0000, 0, 1, 0, 1, 4'b0001});
    tbl.push_back('{4'b0001, 4'b0000, 0, 1, 0, 1, 4'b0001});
    tbl.push_back('{4'b0001, 4'b0001, 0, 1, 0, 1, 4'b0001});
    tbl.push_back('{4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000});
    // round-robin, all valid, single-beat packets
    for (int g = 0; g < 5; g++) begin
      tbl.push_back('{4'b1111, 4'b1111, 0, 0, 0, 0, 4'b0000});
      tbl.push_back('{4'b1111, 4'b1111, 0, 1, 2'((g + 1) % N), 1, N'(1 << ((g + 1) % N))});
    end
    // backpressure mid-packet on requester 2
    tbl.push_back('{4'b0100, 4'b0000, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{4'b0100, 4'b0000, 0, 1, 2, 1, 4'b0100});
    for (int c = 0; c < 4; c++) tbl.push_back('{4'b0100, 4'b0000, 1, 1, 2, 0, 4'b0000});
    tbl.push_back('{4'b0100, 4'b0100, 0, 1, 2, 1, 4'b0100});
    // owner bubble on requester 3 while others valid
    tbl.push_back('{4'b1000, 4'b0000, 0, 0, 0, 0, 4'b0000});
    tbl.push_back('{4'b1000, 4'b0000, 0, 1, 3, 1, 4'b1000});
    for (int c = 0; c < 3; c++) tbl.push_back('{4'b0111, 4'b0000, 0, 1, 3, 0, 4'b0000});
    tbl.push_back('{4'b1111, 4'b1000, 0, 1, 3, 1, 4'b1000});
    tbl.push_back('{4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000});

    ap_rst_n = 1'b0; req_valid = '0; req_last = '0; fifo_w_full = 1'b0; rand_data();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset gv dut%0d", d), 64'(gv[d]), 64'd0);
      chk($sformatf("reset id dut%0d", d), 64'(gid[d]), 64'd0);
      chk($sformatf("reset wen/rdy/data dut%0d", d), {27'd0, wen[d], rdy[d], wd[d]}, 64'd0);
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    mreset();

    foreach (tbl[r]) begin
      req_valid = tbl[r].v; req_last = tbl[r].l; fifo_w_full = tbl[r].f; rand_data();
      @(negedge ap_clk);
      e_wd = tbl[r].gv ? req_data[int'(tbl[r].gid)*W +: W] : '0;
      nvec++;
      if (gv[0] !== tbl[r].gv || wen[0] !== tbl[r].wen || rdy[0] !== tbl[r].rdy ||
          wd[0] !== e_wd || (tbl[r].gv && gid[0] !== tbl[r].gid)) begin
        nerr++;
        $display("FAIL row%0d: got gv=%b id=%0d wen=%b rdy=%b data=%h, expected gv=%b id=%0d wen=%b rdy=%b data=%h",
                 r, gv[0], gid[0], wen[0], rdy[0], wd[0], tbl[r].gv, tbl[r].gid, tbl[r].wen, tbl[r].rdy, e_wd);
      end
      tick_post();
    end

    // async reset mid-packet
    req_valid = 4'b0100; req_last = '0; fifo_w_full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      rand_data(); @(negedge ap_clk); tick_post();
    end
    chk("pre-reset grant held", {gv[0], wen[0], gid[0]}, {1'b1, 1'b1, 2'd2});
    #1 ap_rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("async reset dut%0d", d), {gv[d], wen[d], rdy[d]}, 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    mreset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      rand_data();
      @(negedge ap_clk);
      for (int d = 0; d < 2; d++)
        chk($sformatf("post-reset c%0d dut%0d", c, d), {gv[d], gid[d], wen[d]},
            (c == 0) ? 64'd0 : {1'b1, 2'd0, 1'b1});
      tick_post();
    end

    // MAX_BURST=2: requester 1 long packet, requester 3 single beats
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    mreset();
    req_valid = 4'b1010; req_last = 4'b1000;
    for (int c = 0; c < 7; c++) begin
      rand_data();
      @(negedge ap_clk);
      chk($sformatf("burst c%0d", c), {gv[1], wen[1], bgv[c] ? gid[1] : 2'd0},
          {bgv[c], bgv[c], bgid[c]});
      tick_post();
    end

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 6);
        req_last[i]  = ($urandom_range(0, 9) < 4);
      end
      fifo_w_full = ($urandom_range(0, 3) == 0);
      rand_data();
      @(negedge ap_clk);
      tick_post();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/iob_fifo_sync_wr_arb.md
Name: iob_fifo_sync_wr_arb

Overview:
- Round-robin write arbiter that shares the write port of one iob_fifo_sync instance (symmetric, DATA_W wide) among NUM_REQ producers.
- Per-requester valid/ready/last handshake; grant is held for a whole packet, or until MAX_BURST beats if that is non-zero.
- Drives the FIFO's w_en/w_data and obeys its w_full flag.
- Sits between the engine request generators and the shared command/response FIFO.

Parameters:
- NUM_REQ, 4, number of requesters, 2..16.
- DATA_W, 32, FIFO write data width.
- MAX_BURST, 0, beats per grant before forced release; 0 = unlimited, release only on last.
- ID_W, $clog2(NUM_REQ), width of grant_id.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a beat.
- req_data  in  NUM_REQ*DATA_W  requester i data in slice [i*DATA_W +: DATA_W].
- req_last  in  NUM_REQ  beat is last of packet.
- req_ready  out  NUM_REQ  beat accepted this cycle.
- fifo_w_en  out  1  to FIFO w_en.
- fifo_w_data  out  DATA_W  to FIFO w_data.
- fifo_w_full  in  1  from FIFO w_full.
- grant_valid  out  1  a requester currently owns the port.
- grant_id  out  ID_W  index of owner; valid only when grant_valid=1.

Behaviour:
- Reset (ap_rst_n=0, async):
  - state=IDLE, grant_valid=0, grant_id=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - beat_cnt=0, req_ready=0, fifo_w_en=0.
  - fifo_w_data is don't-care; implement as 0 when not granted.
- State machine, IDLE/GRANT:
  - IDLE: if any req_valid, pick the first set bit searching from (rr_ptr+1) mod NUM_REQ upward with wrap. Register grant_id, set grant_valid=1, go to GRANT. No beat is accepted in the arbitration cycle (1-cycle grant latency).
  - GRANT: combinationally, req_ready[grant_id] = req_valid[grant_id] & ~fifo_w_full. All other req_ready bits are 0.
  - GRANT: fifo_w_en = req_valid[grant_id] & ~fifo_w_full, and fifo_w_data = req_data slice of grant_id. Zero-cycle path from requester to FIFO.
- Transfer and release:
  - A transfer is fifo_w_en=1. On each transfer beat_cnt increments.
  - Release on transfer with req_last[grant_id]=1, or when MAX_BURST!=0 and beat_cnt==MAX_BURST-1.
  - On release: rr_ptr<=grant_id, beat_cnt<=0, grant_valid<=0, state<=IDLE.
  - Re-arbitration happens the next cycle, so a released requester yields for at least one cycle.
- Stalls and idle owner:
  - GRANT with fifo_w_full=1: no transfer, grant held, beat_cnt held.
  - GRANT with req_valid[grant_id]=0: grant held; a packet is never interleaved.
- Fairness: with all requesters continuously valid and single-beat packets, grants rotate 0,1,2,...,NUM_REQ-1,0. Each grant is 1 arbitration cycle + ≥1 transfer cycle.
- Widths: beat_cnt is $clog2(MAX_BURST+1) bits, minimum 1; never wraps because release occurs at MAX_BURST-1. rr_ptr is ID_W bits; the mod-NUM_REQ search handles non-power-of-2 NUM_REQ.
- Ignored inputs: req_last and req_valid of non-granted requesters are ignored. req_last is ignored in IDLE.
- Reset mid-packet: grant dropped immediately and the partial packet in the FIFO stays. Clearing the FIFO via its rst is the system's responsibility, not this block's.
- fifo_w_full is sampled combinationally only; there is no internal buffering, so the block never writes when full.

Test Plan:
- Single requester: req_valid=0001, 3-beat packet (last on beat 3), FIFO not full -> grant_id=0 in cycle 1; fifo_w_en high cycles 1-3 with data D0..D2; grant_valid=0 in cycle 4.
- Round-robin: all 4 valid, single-beat packets -> grant order 0,1,2,3,0; a write every other cycle; 5 writes in 10 cycles.
- Backpressure: grant to 2 mid-packet, fifo_w_full=1 for 4 cycles -> req_ready=0 and fifo_w_en=0 for those cycles; no grant change; packet resumes with the same beat data.
- MAX_BURST=2, requester 1 sends a 5-beat packet while requester 3 also valid -> 2 beats from 1, then grant to 3 (packet end), then 1 resumes.
- Owner bubble: granted requester drops req_valid for 3 cycles while others valid -> grant held, no writes, no switch.
- Async reset asserted mid-packet -> grant_valid, fifo_w_en and req_ready go 0 without a clock edge; after release, the next grant goes to requester 0 when all are valid.
